// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter for a NoC router output port.
// The grant is locked from head flit to tail flit; a release re-arbitrates
// in the same cycle, so consecutive packets are granted without a bubble.
// Optional hold timeout: define RR_ARB_TIMEOUT_EN to force a release after
// MAX_HOLD stalled cycles (timeout output pulses on the forced release).
module rr_packet_arbiter #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_xfer,
  input  logic               i_tail,
  output logic               o_gnt_vld,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic [NUM_REQ-1:0] o_gnt_onehot,
  output logic               o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01
  } state_t;

  localparam logic [IDX_W-1:0] IDX_INVALID    = '1;
  localparam logic [IDX_W-1:0] IDX_RESET_LAST = IDX_W'(NUM_REQ - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_cur_idx;
  logic [IDX_W-1:0]     w_cur_nxt;
  logic [IDX_W-1:0]     r_last_idx;
  logic [IDX_W-1:0]     w_last_nxt;
  logic [IDX_W-1:0]     w_pick_base;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_pick_vld;
  logic                 w_force;
  logic                 w_release;
  logic                 r_gnt_vld;
  logic [IDX_W-1:0]     r_gnt_idx;
  logic [NUM_REQ-1:0]   r_gnt_onehot;

  // On a release the current grantee becomes the lowest-priority requester.
  assign w_pick_base = (r_state == S_BUSY) ? r_cur_idx : r_last_idx;
  assign w_release   = (r_state == S_BUSY) && ((i_xfer && i_tail) || w_force);

  // Circular search starting one past the base index; first set request wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((32'(w_pick_base) + off) % NUM_REQ);
      if (!w_pick_vld && i_req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  // Next-state logic: grant on any request when idle, hold until release.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_idx;
    w_last_nxt  = r_last_idx;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_BUSY;
          w_cur_nxt   = w_pick_idx;
        end
      end
      S_BUSY: begin
        if (w_release) begin
          w_last_nxt = r_cur_idx;
          if (w_pick_vld) begin
            w_cur_nxt = w_pick_idx;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, index and registered grant outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cur_idx    <= IDX_INVALID;
      r_last_idx   <= IDX_RESET_LAST;
      r_gnt_vld    <= 1'b0;
      r_gnt_idx    <= IDX_INVALID;
      r_gnt_onehot <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_idx  <= w_cur_nxt;
      r_last_idx <= w_last_nxt;
      if (w_state_nxt == S_BUSY) begin
        r_gnt_vld    <= 1'b1;
        r_gnt_idx    <= w_cur_nxt;
        r_gnt_onehot <= NUM_REQ'(1) << w_cur_nxt;
      end else begin
        r_gnt_vld    <= 1'b0;
        r_gnt_idx    <= IDX_INVALID;
        r_gnt_onehot <= '0;
      end
    end
  end

  assign o_gnt_vld    = r_gnt_vld;
  assign o_gnt_idx    = r_gnt_idx;
  assign o_gnt_onehot = r_gnt_onehot;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  // Force a release when this stalled cycle would bring the count to MAX_HOLD.
  assign w_force = (r_state == S_BUSY) && !i_xfer &&
                   (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Count stalled busy cycles; any transfer or grant change restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if ((r_state != S_BUSY) || (w_state_nxt != r_state) || i_xfer || w_release) begin
        r_hold_cnt <= '0;
      end else begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_hold;

  assign w_force       = 1'b0;
  assign o_timeout     = 1'b0;
  assign w_unused_hold = (MAX_HOLD == 0);
`endif

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter (default build, 5 requesters).
module tb_rr_packet_arbiter;

  localparam int unsigned N = 5;
  localparam int unsigned W = 3;
  localparam int          INVALID = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] i_req;
  logic         i_xfer;
  logic         i_tail;
  logic         o_gnt_vld;
  logic [W-1:0] o_gnt_idx;
  logic [N-1:0] o_gnt_onehot;
  logic         o_timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: grant owner, previous owner, busy flag.
  bit m_busy;
  int m_cur;
  int m_last;

  typedef struct {
    logic [N-1:0] req;
    logic         xfer;
    logic         tail;
    logic         vld;
    int           idx;
  } vec_t;

  vec_t tbl[$];

  rr_packet_arbiter #(.NUM_REQ(N), .IDX_W(W), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_xfer      (i_xfer),
    .i_tail      (i_tail),
    .o_gnt_vld   (o_gnt_vld),
    .o_gnt_idx   (o_gnt_idx),
    .o_gnt_onehot(o_gnt_onehot),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void add(input logic [N-1:0] r, input logic x, input logic t,
                              input logic v, input int idx);
    vec_t e;
    e.req = r; e.xfer = x; e.tail = t; e.vld = v; e.idx = idx;
    tbl.push_back(e);
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0;
    m_cur  = 0;
    m_last = N - 1;
  endfunction

  // Arbitration by the rules: search from the requester after the base, wrapping.
  function automatic void model_step(input logic [N-1:0] r, input logic x, input logic t);
    int base;
    bit found;
    int idx;
    if (!m_busy) begin
      base = m_last;
    end else if (x && t) begin
      base   = m_cur;
      m_last = m_cur;
    end else begin
      return;
    end
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (base + off) % N;
      if (!found && r[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    m_busy = found;
    if (found) m_cur = idx;
  endfunction

  function automatic void check_model(input string tag);
    check({tag, "_vld"}, int'(o_gnt_vld), int'(m_busy));
    check({tag, "_idx"}, int'(o_gnt_idx), m_busy ? m_cur : INVALID);
    check({tag, "_onehot"}, int'(o_gnt_onehot), m_busy ? (1 << m_cur) : 0);
    check({tag, "_timeout"}, int'(o_timeout), 0);
  endfunction

  // Apply inputs from a falling edge, clock once, return at the next falling edge.
  task automatic cycle(input logic [N-1:0] r, input logic x, input logic t);
    i_req  = r;
    i_xfer = x;
    i_tail = t;
    @(posedge clk);
    if (!reset) model_step(r, x, t);
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    i_req  = '0;
    i_xfer = 1'b0;
    i_tail = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vld", int'(o_gnt_vld), 0);
    check("reset_idx", int'(o_gnt_idx), INVALID);
    check("reset_onehot", int'(o_gnt_onehot), 0);
    check("reset_timeout", int'(o_timeout), 0);
    reset = 1'b0;

    // idle with no requests
    for (int i = 0; i < 5; i++) add(5'b00000, 1'b0, 1'b0, 1'b0, INVALID);
    // rotation 1 -> 2 -> 4 -> 1 with no bubble
    add(5'b10110, 1'b0, 1'b0, 1'b1, 1);
    add(5'b10110, 1'b1, 1'b1, 1'b1, 2);
    add(5'b10110, 1'b1, 1'b1, 1'b1, 4);
    add(5'b10110, 1'b1, 1'b1, 1'b1, 1);
    // grant 2, then requester drops mid-packet; tail without xfer ignored
    add(5'b00100, 1'b1, 1'b1, 1'b1, 2);
    add(5'b00000, 1'b1, 1'b0, 1'b1, 2);
    add(5'b00000, 1'b0, 1'b1, 1'b1, 2);
    add(5'b00000, 1'b1, 1'b0, 1'b1, 2);
    add(5'b00000, 1'b1, 1'b0, 1'b1, 2);
    add(5'b00000, 1'b1, 1'b1, 1'b0, INVALID);
    add(5'b00000, 1'b0, 1'b0, 1'b0, INVALID);
    // single requester, single-flit packets back to back
    add(5'b01000, 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 4; i++) add(5'b01000, 1'b1, 1'b1, 1'b1, 3);
    add(5'b00000, 1'b1, 1'b1, 1'b0, INVALID);
    // xfer while idle is ignored
    add(5'b00000, 1'b1, 1'b1, 1'b0, INVALID);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].req, tbl[i].xfer, tbl[i].tail);
      check($sformatf("row%0d_vld", i), int'(o_gnt_vld), int'(tbl[i].vld));
      check($sformatf("row%0d_idx", i), int'(o_gnt_idx), tbl[i].idx);
      check($sformatf("row%0d_onehot", i), int'(o_gnt_onehot),
            tbl[i].vld ? (1 << tbl[i].idx) : 0);
      check_model($sformatf("row%0d_model", i));
    end

    // asynchronous reset in the middle of a packet granted to 4
    cycle(5'b10000, 1'b0, 1'b0);
    check("pre_reset_idx", int'(o_gnt_idx), 4);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_vld", int'(o_gnt_vld), 0);
    check("async_reset_idx", int'(o_gnt_idx), INVALID);
    check("async_reset_onehot", int'(o_gnt_onehot), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(5'b10001, 1'b0, 1'b0);
    check("post_reset_idx", int'(o_gnt_idx), 0);
    check_model("post_reset");

    // without the timeout feature the grant is held indefinitely
    for (int i = 0; i < 20; i++) begin
      cycle(5'b10001, 1'b0, 1'b0);
      check($sformatf("hold%0d_idx", i), int'(o_gnt_idx), 0);
      check($sformatf("hold%0d_timeout", i), int'(o_timeout), 0);
    end
    cycle(5'b10001, 1'b1, 1'b1);
    check("hold_release_idx", int'(o_gnt_idx), 4);
    check_model("hold_release");

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] r;
      logic         x;
      logic         t;
      r = N'($urandom_range(0, 31));
      x = ($urandom_range(0, 1) == 1);
      t = ($urandom_range(0, 2) == 0);
      cycle(r, x, t);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Parametrised round-robin arbiter for a NoC router output port, choosing among NUM_REQ input virtual-channel buffers.
- Next generation of the fixed 5-way arbiter:
  - requester count and index width are parameters;
  - the grant is locked for a whole packet, from the head flit through to the tail flit;
  - back-to-back re-arbitration is supported with no idle bubble.
- Sits between the VC buffer "not empty" flags and the crossbar select.

Parameters:
- NUM_REQ, 5: number of requesters (N, S, E, W, L by default). Legal range 2..2^IDX_W-1.
- IDX_W, 3: width of the binary grant index. The all-ones value is reserved as INVALID.
- MAX_HOLD, 16: hold-timeout limit in cycles. Used only when RR_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i = buffer i non-empty and wants this output.
- xfer  input  1  the downstream port accepted a flit from the granted requester this cycle.
- tail  input  1  the flit accepted this cycle is a tail flit. Qualified by xfer.
- gnt_vld  output  1  a grant is active.
- gnt_idx  output  IDX_W  binary index of the granted requester. All ones when gnt_vld=0.
- gnt_onehot  output  NUM_REQ  one-hot grant. All zeros when gnt_vld=0.
- timeout  output  1  one-cycle pulse on a forced release. Constant 0 unless RR_ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt_vld=0, gnt_idx=all ones, gnt_onehot=0, timeout=0;
  - last_idx=NUM_REQ-1, so requester 0 has first priority after reset;
  - hold counter=0.
- All outputs are registered. They are decoded from state and cur_idx only; there is no combinational path from req to outputs.
- Round-robin pick function:
  - search starts at (last_idx+1) mod NUM_REQ and wraps circularly;
  - the first set req bit wins;
  - last_idx itself therefore has lowest priority but can still be granted if it is the only requester.
- State IDLE:
  - any req set: next state BUSY, cur_idx=pick, gnt_vld=1 from the next cycle. Latency is one cycle from req to grant.
  - no req: remain in IDLE.
- State BUSY:
  - the grant is held regardless of req changes;
  - a granted requester dropping req mid-packet does not release the grant.
- Release event (xfer && tail in BUSY):
  - last_idx <= cur_idx;
  - pick is evaluated on the same-cycle req, with cur_idx treated as last_idx.
- After a release:
  - a requester is found: stay in BUSY with the new cur_idx. The new grant is visible the next cycle, with no idle cycle between packets.
  - no requester is found: go to IDLE, gnt_vld=0.
- Single-flit packet: xfer && tail in the first granted cycle releases immediately.
- Ignored inputs:
  - xfer while in IDLE is ignored;
  - tail without xfer is ignored.
- State encoding: 2 states plus the cur_idx and last_idx registers. An illegal state recovers to IDLE on the next clock, with gnt_vld=0.
- Reset asserted mid-packet: the grant drops immediately (asynchronously), and arbitration restarts from requester 0 after release.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - a hold counter increments every BUSY cycle without xfer and clears on any xfer or on a state change;
  - when the counter reaches MAX_HOLD, the arbiter performs a forced release (same path as a tail release);
  - timeout pulses 1 for that one cycle and the counter clears.
- Not defined:
  - no counter logic exists;
  - timeout is tied to 0;
  - the grant is held indefinitely until a tail flit.

Test Plan:
- Reset then req=5'b00000 for 5 cycles -> gnt_vld=0, gnt_idx=3'b111, gnt_onehot=0 throughout.
- From reset, req=5'b10110 in one cycle -> next cycle gnt_idx=1.
  - On xfer&tail -> gnt_idx=2 the following cycle, then 4, then 1, with gnt_vld continuously 1.
- Grant to 2, then req[2] dropped and xfer without tail for 3 cycles -> gnt_idx stays 2.
  - xfer&tail with req=0 -> gnt_vld=0 the next cycle.
- Only req[3] held, repeated single-flit packets (xfer&tail every granted cycle) -> gnt_idx=3 on every cycle, no bubble.
- Reset pulsed while granted to 4 -> outputs clear immediately.
  - After release, req=5'b10001 -> gnt_idx=0.
- With RR_ARB_TIMEOUT_EN and MAX_HOLD=4, grant 0 with no xfer -> timeout=1 in the 4th hold cycle and gnt_idx moves to the next requester.
  - Without the macro, the same stimulus keeps gnt_idx=0 for 20 cycles and timeout stays 0.
